fb_scanout: RTL and testbench

Video scanout stage on the `rclk` (pixel clock) domain. It generates raster timing (h/v counters, sync, data-enable) and drives the read port of the ping-pong framebuffer FIFO (`raddr`/`ren` out, `rdata` in). It emits aligned 24-bit RGB pixels with sync to the display encoder. `raddr` runs modulo 1024 so that the FIFO's buffer swap at `raddr == 1023` stays in step with consumption.

---
 rtl/fb_scanout_if.sv | 9 +
 rtl/fb_scanout.sv | 167 ++++++++++++++++
 tb/tb_fb_scanout.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_if.sv
// rtl/fb_scanout_if.sv - read port of the ping-pong framebuffer FIFO
interface fb_scanout_if;
  logic        ren;
  logic [9:0]  raddr;
  logic [31:0] rdata;

  modport master (output ren, output raddr, input rdata);
  modport slave  (input ren, input raddr, output rdata);
endinterface

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - raster timing, FIFO read port and aligned RGB/sync output
// SCANOUT_TEST_PATTERN_EN adds pattern_sel and eight vertical colour bars.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic         rclk,
  input  logic         reset,
  input  logic         enable,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic         pattern_sel,
`endif
  fb_scanout_if.master fifo,
  output logic [23:0]  pix,
  output logic         de,
  output logic         hsync,
  output logic         vsync,
  output logic         frame_sync,
  output logic [15:0]  frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {BLANK = 1'b0, RUN = 1'b1} state_e;

  state_e         state_q, state_d;
  logic           pat_q, pat_d;
  logic [HW-1:0]  h_cnt_q, h_cnt_d;
  logic [VW-1:0]  v_cnt_q, v_cnt_d;
  logic [9:0]     ptr_q, ptr_d;
  logic [15:0]    frame_cnt_q;
  logic           ren_q, rd_d, run_d;
  logic [9:0]     raddr_q;
  logic           de_s2_q, hs_s2_q, vs_s2_q, pat_s2_q;
  logic           de_s3_q, hs_s3_q, vs_s3_q, pat_s3_q;
  logic [2:0]     bar_d, bar_s2_q, bar_s3_q;
  logic [23:0]    pix_q, pix_d;
  logic           de_q, hsync_q, vsync_q;
  logic           frame_start, active, hs_act, vs_act;
  logic           unused_rdata;

  // Inverted bar index carries G in bit 2, R in bit 1, B in bit 0, which
  // yields white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] c;
    c = ~idx;
    return {{8{c[1]}}, {8{c[2]}}, {8{c[0]}}};
  endfunction

  assign frame_start  = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign active       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_act       = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs_act       = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  assign unused_rdata = ^fifo.rdata[31:24];

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  // The frame-start decision must already steer the read issued at (0,0).
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    if (frame_start) begin
      state_d = enable ? RUN : BLANK;
`ifdef SCANOUT_TEST_PATTERN_EN
      pat_d = pattern_sel;
`else
      pat_d = 1'b0;
`endif
    end
    run_d = (state_d == RUN) && active;
    rd_d  = run_d && !pat_d;
    ptr_d = rd_d ? ptr_q + 10'd1 : ptr_q;
  end

  always_comb begin
    bar_d = 3'((32'(h_cnt_q) * 32'd8) / 32'(H_ACTIVE));
  end

  always_comb begin
    pix_d = '0;
    if (de_s3_q) pix_d = pat_s3_q ? bar_rgb(bar_s3_q) : fifo.rdata[23:0];
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      state_q     <= BLANK;
      pat_q       <= 1'b0;
      ptr_q       <= '0;
      frame_cnt_q <= '0;
      ren_q       <= 1'b0;
      raddr_q     <= '0;
      de_s2_q     <= 1'b0;
      hs_s2_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      pat_s2_q    <= 1'b0;
      bar_s2_q    <= '0;
      de_s3_q     <= 1'b0;
      hs_s3_q     <= 1'b0;
      vs_s3_q     <= 1'b0;
      pat_s3_q    <= 1'b0;
      bar_s3_q    <= '0;
      pix_q       <= '0;
      de_q        <= 1'b0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      state_q     <= state_d;
      pat_q       <= pat_d;
      ptr_q       <= ptr_d;
      frame_cnt_q <= frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
      ren_q       <= rd_d;
      raddr_q     <= rd_d ? ptr_q : raddr_q;
      de_s2_q     <= run_d;
      hs_s2_q     <= hs_act;
      vs_s2_q     <= vs_act;
      pat_s2_q    <= pat_d;
      bar_s2_q    <= bar_d;
      de_s3_q     <= de_s2_q;
      hs_s3_q     <= hs_s2_q;
      vs_s3_q     <= vs_s2_q;
      pat_s3_q    <= pat_s2_q;
      bar_s3_q    <= bar_s2_q;
      pix_q       <= pix_d;
      de_q        <= de_s3_q;
      hsync_q     <= hs_s3_q ? HS_POL : ~HS_POL;
      vsync_q     <= vs_s3_q ? VS_POL : ~VS_POL;
    end
  end

  assign fifo.ren    = ren_q;
  assign fifo.raddr  = raddr_q;
  assign pix         = pix_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_sync  = (h_cnt_q == '0) && (v_cnt_q == V_ACT);
  assign frame_count = frame_cnt_q;
endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - randomized scanout bench against a raster-position reference model
module tb_fb_scanout;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int MAXP = 8192;
`ifdef SCANOUT_TEST_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic        rclk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pattern_sel = 1'b0;
  logic [23:0] pix;
  logic        de, hsync, vsync, frame_sync;
  logic [15:0] frame_count;

  fb_scanout_if fifo_if();

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .rclk(rclk),
    .reset(reset),
    .enable(enable),
`ifdef SCANOUT_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .fifo(fifo_if),
    .pix(pix),
    .de(de),
    .hsync(hsync),
    .vsync(vsync),
    .frame_sync(frame_sync),
    .frame_count(frame_count)
  );

  always #5 rclk = ~rclk;

  // FIFO: data is the word address plus a fixed tag, valid the cycle after ren
  always @(posedge rclk) begin
    if (fifo_if.ren) fifo_if.rdata <= 32'h00AABBCC + 32'(fifo_if.raddr);
    else             fifo_if.rdata <= $urandom;
  end

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  bit          rec_de  [MAXP];
  bit          rec_hs  [MAXP];
  bit          rec_vs  [MAXP];
  bit          rec_ren [MAXP];
  logic [9:0]  rec_addr[MAXP];
  logic [23:0] rec_pix [MAXP];

  int c, m_ptr, last_addr, wrap_seen;
  bit m_run, m_pat;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp);
    end
  endtask

  // Expected behaviour of raster position p, derived from its h/v coordinates
  task automatic model_pos(input int p);
    int h, v;
    bit act;
    h = p % HT;
    v = (p / HT) % VT;
    if (h == 0 && v == 0) begin
      m_run = enable;
      m_pat = PAT_EN && pattern_sel;
    end
    act = (h < HA) && (v < VA);
    rec_hs[p]   = !(h >= HA + HF && h < HA + HF + HS);
    rec_vs[p]   = !(v >= VA + VF && v < VA + VF + VS);
    rec_de[p]   = m_run && act;
    rec_ren[p]  = 1'b0;
    rec_addr[p] = '0;
    rec_pix[p]  = '0;
    if (m_run && act) begin
      if (m_pat) begin
        rec_pix[p] = bars[h * 8 / HA];
      end else begin
        rec_ren[p]  = 1'b1;
        rec_addr[p] = 10'(m_ptr);
        rec_pix[p]  = 24'hAABBCC + 24'(m_ptr);
        m_ptr = (m_ptr + 1) % 1024;
      end
    end
  endtask

  task automatic check_cycle();
    bit e_de, e_hs, e_vs, e_ren;
    logic [23:0] e_pix;
    e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_pix = '0; e_ren = 1'b0;
    if (c >= 3) begin
      e_de = rec_de[c-3]; e_hs = rec_hs[c-3]; e_vs = rec_vs[c-3]; e_pix = rec_pix[c-3];
    end
    if (c >= 1) e_ren = rec_ren[c-1];
    chk("de", 32'(de), 32'(e_de));
    chk("pix", 32'(pix), 32'(e_pix));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("ren", 32'(fifo_if.ren), 32'(e_ren));
    if (e_ren) chk("raddr", 32'(fifo_if.raddr), 32'(rec_addr[c-1]));
    chk("frame_sync", 32'(frame_sync), (c % HT == 0 && (c / HT) % VT == VA) ? 32'd1 : 32'd0);
    chk("frame_count", 32'(frame_count), 32'(((c + FT - 1) / FT) % 65536));
    if (fifo_if.ren === 1'b1) begin
      if (last_addr == 1023) begin
        chk("wrap", 32'(fifo_if.raddr), 32'd0);
        wrap_seen++;
      end
      last_addr = int'(fifo_if.raddr);
    end
  endtask

  task automatic run_cycle(input bit en, input bit psel);
    check_cycle();
    enable = en;
    pattern_sel = psel;
    model_pos(c);
    @(posedge rclk); #1;
    c++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge rclk);
    #1;
    reset = 1'b0;
    c = 0; m_ptr = 0; m_run = 1'b0; m_pat = 1'b0; last_addr = -1;
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_ren"}, 32'(fifo_if.ren), 32'd0);
    chk({pfx, "_raddr"}, 32'(fifo_if.raddr), 32'd0);
    chk({pfx, "_de"}, 32'(de), 32'd0);
    chk({pfx, "_pix"}, 32'(pix), 32'd0);
    chk({pfx, "_hsync"}, 32'(hsync), 32'd1);
    chk({pfx, "_vsync"}, 32'(vsync), 32'd1);
    chk({pfx, "_fcount"}, 32'(frame_count), 32'd0);
    chk({pfx, "_fsync"}, 32'(frame_sync), 32'd0);
  endtask

  initial begin
    wrap_seen = 0;
    enable = 1'b1;
    do_reset(3);
    check_reset_state("rst");

    repeat (3) run_cycle(1'b1, 1'b0);
    chk("first_pix", 32'(pix), 32'h00AABBCC);
    chk("first_de", 32'(de), 32'd1);

    while (c < 2 * FT) run_cycle((c % FT == 0) ? 1'b1 : 1'($urandom), 1'b0);

    // Disabled at frame start, raised mid-frame: whole frame stays blank
    while (c < 3 * FT) run_cycle((c < 2 * FT + 40) ? 1'b0 : 1'b1, 1'b0);

    // Enough enabled frames to carry the pointer through 1023 -> 0
    while (c < 37 * FT) run_cycle((c % FT == 0) ? 1'b1 : 1'($urandom), 1'b0);

    while (c < 38 * FT) begin
`ifdef SCANOUT_TEST_PATTERN_EN
      if (c == 37 * FT + 3) chk("bar_white", 32'(pix), 32'h00FFFFFF);
      if (c == 37 * FT + 10) chk("bar_black", 32'(pix), 32'h00000000);
`endif
      run_cycle(1'b1, 1'b1);
    end

    while (c < 40 * FT + 2 * HT + 4) run_cycle(1'($urandom), 1'($urandom));

    do_reset(1);
    check_reset_state("mrst");
    while (c < FT + FT / 2) run_cycle((c == 0) ? 1'b1 : 1'($urandom), 1'($urandom));

    chk("wrap_seen", (wrap_seen > 0) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
